// File: rtl/id_ex_decouple_queue_pkg.sv
// Shared types and parameters for the ID->EX decoupling queue.
package id_ex_decouple_queue_pkg;

    // Default number of decoded instructions buffered between ID and EX.
    localparam int ID_EX_QUEUE_DEPTH = 4;

    // Occupancy type sized to hold 0..ID_EX_QUEUE_DEPTH inclusive.
    typedef logic [$clog2(ID_EX_QUEUE_DEPTH+1)-1:0] id_ex_queue_count_t;

    // Decoded-instruction payload handed from ID to EX; the queue treats it as opaque bits.
    typedef struct packed {
        logic        valid;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest;
        logic [31:0] src1;
        logic [31:0] src2;
    } id_to_ex_bus_t;

    // Pointer width for a ring of 'depth' slots; a single slot still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/id_ex_decouple_queue_pointer.sv
// Ring-buffer index with explicit wrap at DEPTH-1, so non-power-of-two depths work.
module queue_pointer #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] r_ptr;

    // Step the index on advance; reset and clear both return it to slot 0.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + WIDTH'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/id_ex_decouple_queue.sv
// ID->EX decoupling FIFO: decode keeps issuing while execute stalls; flushed on exception/ERET.
module id_ex_decouple_queue
    import id_ex_decouple_queue_pkg::*;
#(
    parameter int DEPTH       = ID_EX_QUEUE_DEPTH,
    parameter int DATA_WIDTH  = $bits(id_to_ex_bus_t),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] occupancy
);

    localparam int                     PTR_WIDTH = ptr_width(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] FULL      = COUNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic [PTR_WIDTH-1:0]   w_head;
    logic [PTR_WIDTH-1:0]   w_tail;
    logic                   w_push;
    logic                   w_pop;

    // Handshake flags come from the registered count only: no out_ready -> in_ready path,
    // so a pop while full cannot admit a push in the same cycle.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[w_head];
    assign occupancy = r_count;

    queue_pointer #(.WIDTH(PTR_WIDTH), .DEPTH(DEPTH)) u_head_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .advance (w_pop),
        .ptr     (w_head)
    );

    queue_pointer #(.WIDTH(PTR_WIDTH), .DEPTH(DEPTH)) u_tail_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .advance (w_push),
        .ptr     (w_tail)
    );

    // Next occupancy: +1 on push, -1 on pop, unchanged when both or neither happen.
    // NOTE: assign a default before any branch so always_comb never infers a latch.
    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + COUNT_WIDTH'(1);
            2'b01:   w_count_next = r_count - COUNT_WIDTH'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy register; reset and flush empty the queue and override any traffic.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Payload storage, written at the tail on every accepted push.
    // NOTE: storage has no reset; out_valid gates its contents, so stale slots are never observed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[w_tail] <= in_data;
        end
    end

endmodule
